// File: rtl/alu_design_if.sv
// alu_design_if: operand/command bus and registered result/status bus of the ALU
interface alu_design_if #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
);
  logic [WIDTH-1:0]     OPA;
  logic [WIDTH-1:0]     OPB;
  logic [CMD_WIDTH-1:0] CMD;
  logic                 CE;
  logic                 CIN;
  logic [1:0]           INP_VALID;
  logic                 MODE;
  logic [2*WIDTH-1:0]   RES;
  logic                 COUT;
  logic                 OFLOW;
  logic                 G;
  logic                 L;
  logic                 E;
  logic                 ERR;
  modport master (
    output OPA, OPB, CMD, CE, CIN, INP_VALID, MODE,
    input  RES, COUT, OFLOW, G, L, E, ERR
  );
  modport slave (
    input  OPA, OPB, CMD, CE, CIN, INP_VALID, MODE,
    output RES, COUT, OFLOW, G, L, E, ERR
  );
endinterface

// File: rtl/alu_design.sv
// alu_design: registered unsigned ALU with arithmetic and logical command sets
module alu_design #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
) (
  input logic         CLK,
  input logic         RST,
  alu_design_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int RW = 2 * WIDTH;
  logic [WIDTH-1:0] a, b;
  logic [RW-1:0]    ax, bx, rot_l, rot_r, res_d, res_q;
  logic [1:0]       iv, need;
  logic             legal, cin, mode;
  logic             cout_d, oflow_d, g_d, l_d, e_d, err_d;
  logic [5:0]       flg_q;
  int unsigned      c;
  assign a     = bus.OPA;
  assign b     = bus.OPB;
  assign iv    = bus.INP_VALID;
  assign cin   = bus.CIN;
  assign mode  = bus.MODE;
  assign c     = 32'(bus.CMD);
  assign ax    = RW'(a);
  assign bx    = RW'(b);
  assign rot_l = {a, a} << b[SW-1:0];
  assign rot_r = {a, a} >> b[SW-1:0];
  // Operand-presence mask each command needs, and whether the command exists at all
  always_comb begin
    need  = mode ? ((c == 4 || c == 5) ? 2'b01 : (c == 6 || c == 7) ? 2'b10 : 2'b11)
                 : ((c == 6 || c == 8 || c == 9) ? 2'b01 : (c == 7 || c == 10 || c == 11) ? 2'b10 : 2'b11);
    legal = mode ? (c <= 10) : (c <= 13);
  end
  // Next result and flags; an error forces everything else to zero except for bad rotate amounts
  always_comb begin
    res_d   = '0;
    cout_d  = 1'b0;
    oflow_d = 1'b0;
    g_d     = 1'b0;
    l_d     = 1'b0;
    e_d     = 1'b0;
    err_d   = 1'b0;
    if (!legal || (need & ~iv) != 2'b00) err_d = 1'b1;
    else if (mode) begin
      case (c)
        0: res_d[WIDTH:0] = {1'b0, a} + {1'b0, b};
        1: begin res_d[WIDTH-1:0] = a - b; oflow_d = a < b; end
        2: res_d[WIDTH:0] = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        3: begin
          res_d[WIDTH-1:0] = a - b - WIDTH'(cin);
          oflow_d = {1'b0, a} < {1'b0, b} + (WIDTH+1)'(cin);
        end
        4: res_d[WIDTH:0] = {1'b0, a} + (WIDTH+1)'(1);
        5: begin res_d[WIDTH-1:0] = a - WIDTH'(1); oflow_d = a == '0; end
        6: res_d[WIDTH:0] = {1'b0, b} + (WIDTH+1)'(1);
        7: begin res_d[WIDTH-1:0] = b - WIDTH'(1); oflow_d = b == '0; end
        8: begin g_d = a > b; l_d = a < b; e_d = a == b; end
        9: res_d = (ax + RW'(1)) * (bx + RW'(1));
        10: res_d = RW'({a[WIDTH-2:0], 1'b0}) * bx;
        default: ;
      endcase
      cout_d = (c == 0 || c == 2 || c == 4 || c == 6) && res_d[WIDTH];
    end else begin
      case (c)
        0: res_d[WIDTH-1:0] = a & b;
        1: res_d[WIDTH-1:0] = ~(a & b);
        2: res_d[WIDTH-1:0] = a | b;
        3: res_d[WIDTH-1:0] = ~(a | b);
        4: res_d[WIDTH-1:0] = a ^ b;
        5: res_d[WIDTH-1:0] = ~(a ^ b);
        6: res_d[WIDTH-1:0] = ~a;
        7: res_d[WIDTH-1:0] = ~b;
        8: res_d[WIDTH-1:0] = a >> 1;
        9: res_d[WIDTH-1:0] = a << 1;
        10: res_d[WIDTH-1:0] = b >> 1;
        11: res_d[WIDTH-1:0] = b << 1;
        12: begin res_d[WIDTH-1:0] = rot_l[RW-1:WIDTH]; err_d = |b[WIDTH-1:SW]; end
        13: begin res_d[WIDTH-1:0] = rot_r[WIDTH-1:0]; err_d = |b[WIDTH-1:SW]; end
        default: ;
      endcase
    end
  end
  // Output registers: reset clears, CE=0 holds
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_q <= '0;
      flg_q <= '0;
    end else if (bus.CE) begin
      res_q <= res_d;
      flg_q <= {cout_d, oflow_d, g_d, l_d, e_d, err_d};
    end
  end
  assign bus.RES   = res_q;
  assign {bus.COUT, bus.OFLOW, bus.G, bus.L, bus.E, bus.ERR} = flg_q;
endmodule

// File: tb/tb_alu_design.sv
// tb_alu_design: directed scoreboard bench for alu_design
module tb_alu_design;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [21:0] exp_q[$];
  string       tag_q[$];
  alu_design_if #(.WIDTH(8), .CMD_WIDTH(4)) bus ();
  alu_design #(.WIDTH(8), .CMD_WIDTH(4)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  // flags field order: {COUT, OFLOW, G, L, E, ERR}
  task automatic step(input string tag, input logic r, input logic ce, input logic md, input int cm,
                      input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic [1:0] iv,
                      input logic [15:0] er, input logic [5:0] ef);
    logic [21:0] got, ex;
    string t;
    rst = r;
    bus.CE = ce;
    bus.MODE = md;
    bus.CMD = 4'(cm);
    bus.OPA = av;
    bus.OPB = bv;
    bus.CIN = ci;
    bus.INP_VALID = iv;
    exp_q.push_back({er, ef});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got = {bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.L, bus.E, bus.ERR};
    ex = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (got === ex) else begin
      errors++;
      $error("FAIL %s: got RES=%h flags=%b, expected RES=%h flags=%b", t, got[21:6], got[5:0], ex[21:6], ex[5:0]);
    end
  endtask
  initial begin
    bus.CE = 1'b1; bus.MODE = 1'b0; bus.CMD = '0; bus.OPA = '0; bus.OPB = '0; bus.CIN = 1'b0; bus.INP_VALID = 2'b00;
    step("reset",      1, 1, 1, 0,  8'hFF, 8'h01, 0, 2'b11, 16'h0000, 6'b000000);
    step("add_ff_01",  0, 1, 1, 0,  8'hFF, 8'h01, 0, 2'b11, 16'h0100, 6'b100000);
    step("sub_3_5",    0, 1, 1, 1,  8'h03, 8'h05, 0, 2'b11, 16'h00FE, 6'b010000);
    step("cmp_eq",     0, 1, 1, 8,  8'h2A, 8'h2A, 0, 2'b11, 16'h0000, 6'b000010);
    step("cmp_gt",     0, 1, 1, 8,  8'h05, 8'h03, 0, 2'b11, 16'h0000, 6'b001000);
    step("cmp_lt",     0, 1, 1, 8,  8'h03, 8'h05, 0, 2'b11, 16'h0000, 6'b000100);
    step("mul_inc",    0, 1, 1, 9,  8'h03, 8'h04, 0, 2'b11, 16'd20,   6'b000000);
    step("mul_inc_ff", 0, 1, 1, 9,  8'hFF, 8'hFE, 0, 2'b11, 16'hFF00, 6'b000000);
    step("mul_shl",    0, 1, 1, 10, 8'h81, 8'h02, 0, 2'b11, 16'h0004, 6'b000000);
    step("add_cin",    0, 1, 1, 2,  8'hFF, 8'h00, 1, 2'b11, 16'h0100, 6'b100000);
    step("sub_cin",    0, 1, 1, 3,  8'h05, 8'h05, 1, 2'b11, 16'h00FF, 6'b010000);
    step("sub_cin_ok", 0, 1, 1, 3,  8'h06, 8'h05, 1, 2'b11, 16'h0000, 6'b000000);
    step("inc_a_iv01", 0, 1, 1, 4,  8'h7F, 8'h00, 0, 2'b01, 16'h0080, 6'b000000);
    step("dec_a_zero", 0, 1, 1, 5,  8'h00, 8'h00, 0, 2'b01, 16'h00FF, 6'b010000);
    step("inc_b_ff",   0, 1, 1, 6,  8'h00, 8'hFF, 0, 2'b10, 16'h0100, 6'b100000);
    step("dec_b_noB",  0, 1, 1, 7,  8'h00, 8'h10, 0, 2'b01, 16'h0000, 6'b000001);
    step("inc_a_iv00", 0, 1, 1, 4,  8'h01, 8'h01, 0, 2'b00, 16'h0000, 6'b000001);
    step("arith_13",   0, 1, 1, 13, 8'h01, 8'h01, 0, 2'b11, 16'h0000, 6'b000001);
    step("rol_ok",     0, 1, 0, 12, 8'h81, 8'h01, 0, 2'b11, 16'h0003, 6'b000000);
    step("rol_bad",    0, 1, 0, 12, 8'h81, 8'h11, 0, 2'b11, 16'h0003, 6'b000001);
    step("ror_3",      0, 1, 0, 13, 8'h81, 8'h03, 0, 2'b11, 16'h0030, 6'b000000);
    step("and_noB",    0, 1, 0, 0,  8'hFF, 8'hFF, 0, 2'b01, 16'h0000, 6'b000001);
    step("nand",       0, 1, 0, 1,  8'hF0, 8'h3C, 0, 2'b11, 16'h00CF, 6'b000000);
    step("xnor",       0, 1, 0, 5,  8'hF0, 8'h3C, 0, 2'b11, 16'h0033, 6'b000000);
    step("nor",        0, 1, 0, 3,  8'hF0, 8'h0C, 0, 2'b11, 16'h0003, 6'b000000);
    step("shr1_a",     0, 1, 0, 8,  8'h81, 8'h00, 0, 2'b01, 16'h0040, 6'b000000);
    step("shl1_b",     0, 1, 0, 11, 8'h00, 8'h81, 0, 2'b10, 16'h0002, 6'b000000);
    step("not_b",      0, 1, 0, 7,  8'h00, 8'h5A, 0, 2'b10, 16'h00A5, 6'b000000);
    step("logic_14",   0, 1, 0, 14, 8'h01, 8'h01, 0, 2'b11, 16'h0000, 6'b000001);
    step("add_5_6",    0, 1, 1, 0,  8'h05, 8'h06, 0, 2'b11, 16'h000B, 6'b000000);
    step("hold_1",     0, 0, 1, 0,  8'hFF, 8'hFF, 0, 2'b11, 16'h000B, 6'b000000);
    step("hold_2",     0, 0, 1, 1,  8'h00, 8'h01, 0, 2'b11, 16'h000B, 6'b000000);
    step("ce_back",    0, 1, 1, 0,  8'h01, 8'h01, 0, 2'b11, 16'h0002, 6'b000000);
    step("err_clears", 0, 1, 1, 15, 8'h01, 8'h01, 0, 2'b11, 16'h0000, 6'b000001);
    step("err_gone",   0, 1, 1, 0,  8'h10, 8'h20, 0, 2'b11, 16'h0030, 6'b000000);
    step("reset_ce0",  1, 0, 1, 0,  8'hFF, 8'h01, 0, 2'b11, 16'h0000, 6'b000000);
    step("after_rst",  0, 1, 1, 1,  8'h05, 8'h03, 0, 2'b11, 16'h0002, 6'b000000);
    step("reset_ce1",  1, 1, 1, 0,  8'hFF, 8'h01, 0, 2'b11, 16'h0000, 6'b000000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
